// File: rtl/axi_sram_subordinate.sv
// axi_sram_subordinate: AXI-style SRAM subordinate serving line-sized write/read bursts.
//   clk, rst                      : clock, synchronous active-high reset
//   aw*/w*/b*                     : write request, write beats, write response
//   ar*/r*                        : read request, read beats (rdata registered)
//   AW_WORDS                      : log2 SRAM depth in 32-bit words
//   BEATS                         : 32-bit beats per line, power of two
module axi_sram_subordinate #(
   parameter int AW_WORDS = 12,
   parameter int BEATS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [5:0]  awatop,
   input  logic        wvalid,
   output logic        wready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   output logic        bvalid,
   input  logic        bready,
   output logic [3:0]  bid,
   output logic        bcomp,
   input  logic        arvalid,
   output logic        arready,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   output logic        rvalid,
   input  logic        rready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic        rlast
);
   localparam int BW = $clog2(BEATS);
   localparam int LW = AW_WORDS - BW;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;
   wstate_t ws, ws_n;
   rstate_t rs, rs_n;
   logic [31:0] mem [2**AW_WORDS];
   logic [LW-1:0] wline, rline;
   // one extra bit so beats past the end of the line are recognisable
   logic [BW:0] wbeat;
   logic [BW-1:0] rbeat;
   logic wok, aw_hs, w_hs, ar_hs, r_hs, r_adv, we, unused_bits;
   logic [AW_WORDS-1:0] widx, ridx;
   always_comb begin
      awready = ~rst & (ws == W_IDLE);
      wready = ~rst & (ws == W_DATA);
      bvalid = ~rst & (ws == W_RESP);
      bcomp = bvalid & wok;
      arready = ~rst & (rs == R_IDLE);
      rvalid = ~rst & (rs == R_DATA);
      rlast = rvalid & (rbeat == BW'(BEATS - 1));
      aw_hs = awvalid & awready;
      w_hs = wvalid & wready;
      ar_hs = arvalid & arready;
      r_hs = rvalid & rready;
      r_adv = r_hs & ~rlast;
      we = w_hs & wok & ~wbeat[BW];
      ws_n = aw_hs ? W_DATA : (w_hs & wlast) ? W_RESP : (bvalid & bready) ? W_IDLE : ws;
      rs_n = ar_hs ? R_DATA : (r_hs & rlast) ? R_IDLE : rs;
      widx = {wline, wbeat[BW-1:0]};
      // the next word is fetched on the accepting edge so beats stream without bubbles
      ridx = ar_hs ? {araddr[AW_WORDS+1:BW+2], BW'(0)} : {rline, rbeat + BW'(1)};
      unused_bits = ^{awaddr[31:AW_WORDS+2], awaddr[BW+1:0], araddr[31:AW_WORDS+2], araddr[BW+1:0]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ws <= W_IDLE;
         rs <= R_IDLE;
         wok <= 1'b0;
         wbeat <= '0;
         wline <= '0;
         bid <= '0;
         rbeat <= '0;
         rline <= '0;
         rid <= '0;
         rdata <= '0;
      end else begin
         ws <= ws_n;
         rs <= rs_n;
         if (aw_hs) begin
            bid <= awid;
            wline <= awaddr[AW_WORDS+1:BW+2];
            wok <= (awatop == 6'd0);
            wbeat <= '0;
         end else if (w_hs) begin
            wbeat <= wbeat + (BW+1)'(1);
            if (wbeat[BW]) wok <= 1'b0;
         end
         // sampled before this edge's SRAM write lands, giving read-before-write
         if (ar_hs | r_adv) rdata <= mem[ridx];
         if (ar_hs) begin
            rid <= arid;
            rline <= araddr[AW_WORDS+1:BW+2];
            rbeat <= '0;
         end else if (r_adv) rbeat <= rbeat + BW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (we)
         for (int i = 0; i < 4; i++)
            if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
   end
endmodule
